enc8to3_serial: RTL and testbench

//  Inverse of the 3-to-8 decoder path: accepts an N-bit multi-hot request vector and emits
//  the index of every set bit, lowest first, one index per handshake on the output side.

---
 rtl/enc8to3_serial_pkg.sv | 10 +
 rtl/prio_enc8to3.sv | 26 ++
 rtl/enc8to3_serial.sv | 66 ++++++
 tb/tb_enc8to3_serial.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/enc8to3_serial_pkg.sv
// Shared defaults and FSM state encodings for the serial multi-hot to index encoder.
package enc8to3_serial_pkg;

   localparam int N_DEF  = 8;
   localparam int IW_DEF = 3;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_EMIT = 1'b1;

endpackage

// File: rtl/prio_enc8to3.sv
// Lowest-set-bit priority encoder with any/exactly-one flags.
// Latency: combinational; backpressure: none (pure function of vec).
module prio_enc8to3 #(
   parameter int N  = 8,
   parameter int IW = 3
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          one
);

   always_comb begin
      idx = '0;
      // Scan from the top so the lowest set bit is the last writer.
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) begin
            idx = IW'(i);
         end
      end
   end

   assign any = |vec;
   assign one = any && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/enc8to3_serial.sv
// Serialises a multi-hot vector into ascending bit indices, one per output handshake.
// Latency: first index 1 cycle after accept; backpressure: out_ready stalls, in_ready only on last.
module enc8to3_serial
   import enc8to3_serial_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int IW = IW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_vec,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_last,
   output logic          drop
);

   logic [0:0]   state;
   logic [N-1:0] pending;
   logic         pend_any;
   logic         in_fire;
   logic         out_fire;
   logic         vec_zero;
   logic [N-1:0] clr_mask;

   prio_enc8to3 #(
      .N  (N),
      .IW (IW)
   ) u_prio (
      .vec (pending),
      .idx (out_idx),
      .any (pend_any),
      .one (out_last)
   );

   assign out_valid = (state == ST_EMIT) && pend_any;
   // A new vector may only enter as the final index of the current one leaves.
   assign in_ready  = !rst && ((state == ST_IDLE) || (out_ready && out_last));
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = out_valid && out_ready;
   assign vec_zero  = (in_vec == '0);
   assign clr_mask  = N'(1) << out_idx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         pending <= '0;
         drop    <= 1'b0;
      end else begin
         drop <= in_fire && vec_zero;
         if (in_fire && !vec_zero) begin
            pending <= in_vec;
            state   <= ST_EMIT;
         end else if (out_fire) begin
            pending <= pending & ~clr_mask;
            if (out_last) begin
               state <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_enc8to3_serial.sv
// Directed bench for enc8to3_serial with a small index-order scoreboard for the all-ones case.
module tb_enc8to3_serial;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_vec;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] out_idx;
   logic       out_last;
   logic       drop;

   int n_chk = 0;
   int n_err = 0;

   enc8to3_serial dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last),
      .drop      (drop)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int         exp_q[$];
      int         e;
      int         hs;
      logic       stalled;
      logic [2:0] held;
      logic [7:0] vec;

      rst       = 1'b1;
      in_valid  = 1'b0;
      in_vec    = 8'h00;
      out_ready = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_drop", drop, 0);
      chk("rst_out_idx", out_idx, 0);
      chk("rst_out_last", out_last, 0);
      cyc();
      cyc();
      rst = 1'b0;
      #2;
      chk("idle_in_ready", in_ready, 1);

      // 1: reset while a vector is half emitted
      cyc();
      in_valid = 1'b1;
      in_vec   = 8'b1010_0000;
      cyc();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #2;
      chk("t1_pre_valid", out_valid, 1);
      chk("t1_pre_idx", out_idx, 5);
      rst = 1'b1;
      #1;
      chk("t1_rst_valid", out_valid, 0);
      chk("t1_rst_in_ready", in_ready, 0);
      cyc();
      cyc();
      rst       = 1'b0;
      out_ready = 1'b1;
      #2;
      chk("t1_rel_in_ready", in_ready, 1);
      for (int c = 0; c < 3; c++) begin
         chk("t1_no_stale", out_valid, 0);
         cyc();
      end

      // 2: three indices back to back
      in_valid = 1'b1;
      in_vec   = 8'b1001_0010;
      #2;
      chk("t2_acc_valid", out_valid, 0);
      chk("t2_acc_in_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      in_vec   = 8'hC3;
      #2;
      chk("t2_idx_a", out_idx, 1);
      chk("t2_last_a", out_last, 0);
      chk("t2_valid_a", out_valid, 1);
      cyc();
      #2;
      chk("t2_idx_b", out_idx, 4);
      chk("t2_last_b", out_last, 0);
      cyc();
      #2;
      chk("t2_idx_c", out_idx, 7);
      chk("t2_last_c", out_last, 1);
      cyc();
      #2;
      chk("t2_end_valid", out_valid, 0);
      chk("t2_end_in_ready", in_ready, 1);

      // 3: stall holds the presented index; in_vec churn is ignored
      cyc();
      in_valid  = 1'b1;
      in_vec    = 8'b0000_0110;
      out_ready = 1'b0;
      cyc();
      in_vec = 8'h55;
      for (int c = 0; c < 3; c++) begin
         #2;
         chk("t3_hold_idx", out_idx, 1);
         chk("t3_hold_last", out_last, 0);
         chk("t3_hold_in_ready", in_ready, 0);
         cyc();
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      #2;
      chk("t3_idx_a", out_idx, 1);
      cyc();
      #2;
      chk("t3_idx_b", out_idx, 2);
      chk("t3_last_b", out_last, 1);
      cyc();
      #2;
      chk("t3_end_valid", out_valid, 0);

      // 4: second vector accepted on the last handshake of the first
      cyc();
      in_valid = 1'b1;
      in_vec   = 8'b0000_1000;
      cyc();
      in_vec = 8'b0100_0001;
      #2;
      chk("t4_idx_a", out_idx, 3);
      chk("t4_last_a", out_last, 1);
      chk("t4_in_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      #2;
      chk("t4_valid_b", out_valid, 1);
      chk("t4_idx_b", out_idx, 0);
      chk("t4_last_b", out_last, 0);
      cyc();
      #2;
      chk("t4_idx_c", out_idx, 6);
      chk("t4_last_c", out_last, 1);
      cyc();
      #2;
      chk("t4_end_valid", out_valid, 0);

      // 5: zero vector in IDLE and zero vector on a last handshake
      cyc();
      in_valid = 1'b1;
      in_vec   = 8'h00;
      #2;
      chk("t5_in_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      #2;
      chk("t5_drop", drop, 1);
      chk("t5_valid", out_valid, 0);
      chk("t5_in_ready_after", in_ready, 1);
      cyc();
      #2;
      chk("t5_drop_once", drop, 0);
      in_valid = 1'b1;
      in_vec   = 8'b0000_0100;
      cyc();
      in_vec = 8'h00;
      #2;
      chk("t5b_idx", out_idx, 2);
      chk("t5b_in_ready", in_ready, 1);
      cyc();
      in_valid = 1'b0;
      #2;
      chk("t5b_drop", drop, 1);
      chk("t5b_valid", out_valid, 0);

      // 6: all ones with random backpressure against an ordering model
      cyc();
      vec      = 8'hFF;
      in_valid = 1'b1;
      in_vec   = vec;
      for (int i = 0; i < 8; i++) begin
         if (vec[i]) exp_q.push_back(i);
      end
      cyc();
      in_valid = 1'b0;
      hs       = 0;
      stalled  = 1'b0;
      held     = '0;
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
         out_ready = 1'($urandom_range(0, 1));
         #2;
         if (stalled) chk("t6_hold", out_idx, held);
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            chk("t6_idx", out_idx, e);
            chk("t6_last", out_last, exp_q.size() == 0);
            hs++;
            stalled = 1'b0;
         end else if (out_valid) begin
            stalled = 1'b1;
            held    = out_idx;
         end else begin
            chk("t6_valid", out_valid, 1);
         end
         cyc();
      end
      out_ready = 1'b0;
      #2;
      chk("t6_count", hs, $countones(vec));
      chk("t6_done_valid", out_valid, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
